// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-word bit positions, the bubble value and opcodes.
package mips_pkg;

  localparam int unsigned CTRL_REGDST   = 8;
  localparam int unsigned CTRL_ALUSRC   = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_REGWRITE = 5;
  localparam int unsigned CTRL_MEMREAD  = 4;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_BRANCH   = 2;
  localparam int unsigned CTRL_ALUOP_HI = 1;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  localparam logic [8:0] CTRL_BUBBLE = 9'b0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

endpackage

// File: rtl/ctrl_pipe_reg.sv
// Pipeline stage register with asynchronous clear; a bubble request overrides load.
module ctrl_pipe_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= '0;
    else if (bubble) q <= '0;
    else if (load)   q <= d;
  end

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, branch flush
// and saturating stall/flush event counters.
module control_pipeline #(
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              flush,
  output logic              stall,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_dest,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              mem_branch,
  output logic              mem_reg_write,
  output logic [RA_W-1:0]   mem_dest,
  output logic              wb_memto_reg,
  output logic              wb_reg_write,
  output logic [RA_W-1:0]   wb_dest,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  import mips_pkg::*;

  localparam int unsigned IDEX_W  = CTRL_W + 3 * RA_W;
  localparam int unsigned EXMEM_W = 5 + RA_W;
  localparam int unsigned MEMWB_W = 2 + RA_W;

  logic [CTRL_W-1:0] id_clean;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [RA_W-1:0]   ex_rd;
  logic              uses_rt;
  logic              hazard;
  logic              mem_memto_reg;

  always_comb begin
    id_clean = id_ctrl;
    if (!id_ctrl[CTRL_REGWRITE]) begin
      id_clean[CTRL_REGDST]   = 1'b0;
      id_clean[CTRL_MEMTOREG] = 1'b0;
    end
    if (id_ctrl[CTRL_ALUOP_HI]) id_clean[CTRL_ALUOP_LO] = 1'b0;
  end

  assign uses_rt = !id_ctrl[CTRL_ALUSRC] | id_ctrl[CTRL_MEMWRITE];
  assign hazard  = ex_ctrl[CTRL_MEMREAD] & (ex_rt != '0) &
                   ((ex_rt == id_rs) | ((ex_rt == id_rt) & uses_rt)) & id_valid;
  // A taken branch squashes the dependent instruction anyway, so it never stalls.
  assign stall   = hazard & !flush;

  ctrl_pipe_reg #(.W(IDEX_W)) u_id_ex (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (stall | flush | !id_valid),
    .d      ({id_clean, id_rs, id_rt, id_rd}),
    .q      ({ex_ctrl, ex_rs, ex_rt, ex_rd})
  );

  assign ex_reg_dst = ex_ctrl[CTRL_REGDST];
  assign ex_alu_src = ex_ctrl[CTRL_ALUSRC];
  assign ex_alu_op  = {ex_ctrl[CTRL_ALUOP_HI], ex_ctrl[CTRL_ALUOP_LO]};
  assign ex_dest    = ex_reg_dst ? ex_rd : ex_rt;

  ctrl_pipe_reg #(.W(EXMEM_W)) u_ex_mem (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (flush),
    .d      ({ex_ctrl[CTRL_MEMTOREG], ex_ctrl[CTRL_REGWRITE], ex_ctrl[CTRL_MEMREAD],
              ex_ctrl[CTRL_MEMWRITE], ex_ctrl[CTRL_BRANCH], ex_dest}),
    .q      ({mem_memto_reg, mem_reg_write, mem_mem_read,
              mem_mem_write, mem_branch, mem_dest})
  );

  ctrl_pipe_reg #(.W(MEMWB_W)) u_mem_wb (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (1'b0),
    .d      ({mem_memto_reg, mem_reg_write, mem_dest}),
    .q      ({wb_memto_reg, wb_reg_write, wb_dest})
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
